// File: rtl/efx_ram5k_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// efx_ram5k_fifo_ctrl
//   Synchronous FIFO controller that sequences one EFX_RAM_5K primitive used in
//   256x20 mode. It owns the write/read pointers and the full/empty/count state.
//   It drives the RAM write and read address/enable pins, and it returns read
//   data with a fixed latency and a one-cycle valid strobe.
//
//   Optional feature macro: EFX_FIFO_CTRL_ALMOST_FLAGS_EN
//     When defined, the ALMOST_FULL (COUNT >= AF_LEVEL) and ALMOST_EMPTY
//     (COUNT <= AE_LEVEL) output ports are added. When it is not defined, both
//     ports are absent and AF_LEVEL/AE_LEVEL have no effect.
//
// Ports
//   CLK        in   clock, rising edge (also the RAM WCLK/RCLK)
//   SR         in   asynchronous active-high reset
//   WR_EN      in   write request
//   WR_DATA    in   write word
//   RD_EN      in   read request
//   RD_DATA    out  read word (pass-through of RAM_RDATA)
//   RD_VALID   out  RD_DATA holds the word of an accepted read
//   FULL       out  COUNT == 2**ADDR_WIDTH
//   EMPTY      out  COUNT == 0
//   COUNT      out  stored words, 0..2**ADDR_WIDTH
//   OVERFLOW   out  sticky: write requested while FULL
//   UNDERFLOW  out  sticky: read requested while EMPTY
//   RAM_WADDR  out  RAM write address
//   RAM_WDATA  out  RAM write data (WR_DATA pass-through)
//   RAM_WE     out  RAM write enable (active-high)
//   RAM_RADDR  out  RAM read address
//   RAM_RE     out  RAM read enable (active-high)
//   RAM_RDATA  in   RAM read data
//
// Handshake: a write is accepted when WR_EN=1 and FULL=0. A read is accepted
//   when RD_EN=1 and EMPTY=0. Acceptance is decided from the registered flags
//   only, so a read in the same cycle never makes room for a write when the
//   FIFO is full. Likewise, a write in the same cycle never supplies a word to
//   a read when the FIFO is empty. Each accepted read yields exactly one
//   RD_VALID pulse, 1+OUTPUT_REG cycles later.
// -----------------------------------------------------------------------------
module efx_ram5k_fifo_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 20,
  parameter int OUTPUT_REG = 0,
  parameter int AF_LEVEL   = 240,
  parameter int AE_LEVEL   = 16
) (
  input  logic                  CLK,
  input  logic                  SR,
  input  logic                  WR_EN,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  RD_EN,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_VALID,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW,
  output logic [ADDR_WIDTH-1:0] RAM_WADDR,
  output logic [DATA_WIDTH-1:0] RAM_WDATA,
  output logic                  RAM_WE,
  output logic [ADDR_WIDTH-1:0] RAM_RADDR,
  output logic                  RAM_RE,
  input  logic [DATA_WIDTH-1:0] RAM_RDATA
`ifdef EFX_FIFO_CTRL_ALMOST_FLAGS_EN
  ,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY
`endif
);

  logic [ADDR_WIDTH:0] wptr, rptr;
  logic [ADDR_WIDTH:0] wptr_nxt, rptr_nxt, count_nxt;
  logic                full_nxt, empty_nxt;
  logic                wacc, racc;
  logic                vld_q;

  assign wacc = WR_EN & ~FULL;
  assign racc = RD_EN & ~EMPTY;

  assign RAM_WE    = wacc;
  assign RAM_WADDR = wptr[ADDR_WIDTH-1:0];
  assign RAM_WDATA = WR_DATA;
  assign RAM_RE    = racc;
  assign RAM_RADDR = rptr[ADDR_WIDTH-1:0];
  assign RD_DATA   = RAM_RDATA;

  // The flags are registered from the post-edge pointer values, so they
  // always describe the state after the most recent edge.
  assign wptr_nxt  = wptr + {{ADDR_WIDTH{1'b0}}, wacc};
  assign rptr_nxt  = rptr + {{ADDR_WIDTH{1'b0}}, racc};
  assign count_nxt = wptr_nxt - rptr_nxt;
  assign full_nxt  = (wptr_nxt[ADDR_WIDTH] != rptr_nxt[ADDR_WIDTH]) &&
                     (wptr_nxt[ADDR_WIDTH-1:0] == rptr_nxt[ADDR_WIDTH-1:0]);
  assign empty_nxt = (wptr_nxt == rptr_nxt);

  always_ff @(posedge CLK or posedge SR) begin
    if (SR) begin
      wptr      <= '0;
      rptr      <= '0;
      COUNT     <= '0;
      FULL      <= 1'b0;
      EMPTY     <= 1'b1;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      wptr      <= wptr_nxt;
      rptr      <= rptr_nxt;
      COUNT     <= count_nxt;
      FULL      <= full_nxt;
      EMPTY     <= empty_nxt;
      OVERFLOW  <= OVERFLOW | (WR_EN & FULL);
      UNDERFLOW <= UNDERFLOW | (RD_EN & EMPTY);
      vld_q     <= racc;
    end
  end

  // With the RAM output register enabled, the data appears one edge later,
  // so the valid strobe gets a matching extra stage.
  if (OUTPUT_REG != 0) begin : g_oreg
    logic vld_d;
    always_ff @(posedge CLK or posedge SR) begin
      if (SR) vld_d <= 1'b0;
      else    vld_d <= vld_q;
    end
    assign RD_VALID = vld_d;
  end else begin : g_noreg
    assign RD_VALID = vld_q;
  end

`ifdef EFX_FIFO_CTRL_ALMOST_FLAGS_EN
  localparam logic [ADDR_WIDTH:0] AF_THR = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_THR = AE_LEVEL[ADDR_WIDTH:0];

  always_ff @(posedge CLK or posedge SR) begin
    if (SR) begin
      ALMOST_FULL  <= 1'b0;
      ALMOST_EMPTY <= 1'b1;
    end else begin
      ALMOST_FULL  <= (count_nxt >= AF_THR);
      ALMOST_EMPTY <= (count_nxt <= AE_THR);
    end
  end
`endif

endmodule
